// File: rtl/multi_prescaler.sv
// multi_prescaler: NUM_CH independent clock prescalers sharing one clock and
// one phase-sync strobe. Each channel emits a one-cycle tick per period and a
// divided toggle clock. Divisor updates go through a shadow register and are
// applied only at a period boundary, so outputs never glitch.
module multi_prescaler #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       pend_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_sh_q, div_sh_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic [CNT_W-1:0] div_in;
    logic             tc;

    assign div_in = div_i[c*CNT_W +: CNT_W];
    // Terminal count: the counter never runs past the active divisor.
    assign tc     = (cnt_q == div_act_q);

    // Next-state: sync beats run/pause; a load always lands in the shadow.
    always_comb begin
      cnt_d     = cnt_q;
      div_act_d = div_act_q;
      div_sh_d  = div_sh_q;
      pend_d    = pend_q;
      tick_d    = 1'b0;
      clk_d     = clk_q;
      if (sync_i) begin
        // Restart in phase; a waiting divisor is applied with the restart.
        cnt_d = '0;
        clk_d = 1'b0;
        if (pend_q) begin
          div_act_d = div_sh_q;
          pend_d    = 1'b0;
        end
      end else if (en_i[c]) begin
        if (tc) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          clk_d  = ~clk_q;
          // A load coinciding with terminal count supersedes the older
          // pending value; the fresh one applies at the following boundary.
          if (pend_q && !load_i[c]) begin
            div_act_d = div_sh_q;
            pend_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (pend_q) begin
        // Paused channel: no boundary will come, so apply now from zero.
        div_act_d = div_sh_q;
        pend_d    = 1'b0;
        cnt_d     = '0;
      end
      if (load_i[c]) begin
        div_sh_d = div_in;
        pend_d   = 1'b1;
      end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q     <= '0;
        div_act_q <= RST_DIV;
        div_sh_q  <= RST_DIV;
        pend_q    <= 1'b0;
        tick_q    <= 1'b0;
        clk_q     <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        div_act_q <= div_act_d;
        div_sh_q  <= div_sh_d;
        pend_q    <= pend_d;
        tick_q    <= tick_d;
        clk_q     <= clk_d;
      end
    end

    assign tick_o[c] = tick_q;
    assign clk_o[c]  = clk_q;
    assign pend_o[c] = pend_q;
  end

endmodule

// File: tb/tb_multi_prescaler.sv
// Directed bench for multi_prescaler: NUM_CH=4, CNT_W=4, RESET_DIV=0.
// Outputs are sampled 1 time unit after each rising edge.
module tb_multi_prescaler;
  localparam int NC = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   en;
  logic [NC*CW-1:0] div;
  logic [NC-1:0]   load;
  logic            sync;
  logic [NC-1:0]   tick_o, clk_o, pend_o;

  int errs   = 0;
  int checks = 0;

  multi_prescaler #(.NUM_CH(NC), .CNT_W(CW), .RESET_DIV(0)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .div_i(div), .load_i(load),
    .sync_i(sync), .tick_o(tick_o), .clk_o(clk_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int c, input int v);
    div[c*CW +: CW] = CW'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; load = '0; sync = 1'b0; div = '0;
    step();
    rst = 1'b0;
  endtask

  // Capture a divisor while disabled, then let the paused-apply edge take it.
  task automatic program_ch(input int c, input int v);
    set_div(c, v);
    load = NC'(1) << c;
    step();
    load = '0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '1; load = '1; sync = 1'b0; div = '1;
    step();
    checks++; if (tick_o !== 4'b0000) begin errs++; $display("FAIL reset_tick got=%b exp=0000", tick_o); end
    checks++; if (clk_o !== 4'b0000) begin errs++; $display("FAIL reset_clk got=%b exp=0000", clk_o); end
    checks++; if (pend_o !== 4'b0000) begin errs++; $display("FAIL reset_pend got=%b exp=0000", pend_o); end
  endtask

  task automatic test_div3();
    logic et, ec;
    do_reset();
    set_div(0, 3); load = 4'b0001;
    step();
    load = '0;
    checks++; if (pend_o !== 4'b0001) begin errs++; $display("FAIL div3_pend_set got=%b exp=0001", pend_o); end
    step();
    checks++; if (pend_o !== 4'b0000) begin errs++; $display("FAIL div3_pend_clr got=%b exp=0000", pend_o); end
    en = 4'b0001; ec = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      et = (i % 4 == 0); ec = ec ^ et;
      checks++; if (tick_o[0] !== et) begin errs++; $display("FAIL div3_tick i=%0d got=%b exp=%b", i, tick_o[0], et); end
      checks++; if (clk_o[0] !== ec) begin errs++; $display("FAIL div3_clk i=%0d got=%b exp=%b", i, clk_o[0], ec); end
      checks++; if (pend_o !== 4'b0000) begin errs++; $display("FAIL div3_pend i=%0d got=%b exp=0000", i, pend_o); end
    end
    checks++; if (tick_o[3:1] !== 3'b000) begin errs++; $display("FAIL div3_idle_ch got=%b exp=000", tick_o[3:1]); end
  endtask

  task automatic test_div0();
    logic ec;
    do_reset();
    en = 4'b0010; ec = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      ec = ~ec;
      checks++; if (tick_o[1] !== 1'b1) begin errs++; $display("FAIL div0_tick i=%0d got=%b exp=1", i, tick_o[1]); end
      checks++; if (clk_o[1] !== ec) begin errs++; $display("FAIL div0_clk i=%0d got=%b exp=%b", i, clk_o[1], ec); end
    end
  endtask

  task automatic test_div_max();
    logic et, ec;
    do_reset();
    program_ch(3, 15);
    en = 4'b1000; ec = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      et = (i % 16 == 0); ec = ec ^ et;
      checks++; if (tick_o[3] !== et) begin errs++; $display("FAIL divmax_tick i=%0d got=%b exp=%b", i, tick_o[3], et); end
      checks++; if (clk_o[3] !== ec) begin errs++; $display("FAIL divmax_clk i=%0d got=%b exp=%b", i, clk_o[3], ec); end
    end
  endtask

  task automatic test_load_mid();
    logic et, ec, ep;
    do_reset();
    program_ch(0, 9);
    set_div(0, 2);
    en = 4'b0001; ec = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      load = (i == 5) ? 4'b0001 : 4'b0000;
      step();
      et = (i == 10 || i == 13 || i == 16 || i == 19);
      ep = (i >= 5 && i < 10);
      ec = ec ^ et;
      checks++; if (tick_o[0] !== et) begin errs++; $display("FAIL loadmid_tick i=%0d got=%b exp=%b", i, tick_o[0], et); end
      checks++; if (clk_o[0] !== ec) begin errs++; $display("FAIL loadmid_clk i=%0d got=%b exp=%b", i, clk_o[0], ec); end
      checks++; if (pend_o[0] !== ep) begin errs++; $display("FAIL loadmid_pend i=%0d got=%b exp=%b", i, pend_o[0], ep); end
    end
    load = '0;
  endtask

  task automatic test_load_tc();
    logic et, ep;
    do_reset();
    program_ch(0, 5);
    set_div(0, 1);
    en = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      load = (i == 6) ? 4'b0001 : 4'b0000;
      step();
      et = (i == 6 || i == 12 || i == 14 || i == 16);
      ep = (i >= 6 && i < 12);
      checks++; if (tick_o[0] !== et) begin errs++; $display("FAIL loadtc_tick i=%0d got=%b exp=%b", i, tick_o[0], et); end
      checks++; if (pend_o[0] !== ep) begin errs++; $display("FAIL loadtc_pend i=%0d got=%b exp=%b", i, pend_o[0], ep); end
    end
    load = '0;
  endtask

  task automatic test_back_to_back();
    logic et;
    do_reset();
    program_ch(0, 5);
    en = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      load = (i == 2 || i == 3) ? 4'b0001 : 4'b0000;
      set_div(0, (i == 2) ? 3 : 1);
      step();
      et = (i == 6 || i == 8 || i == 10);
      checks++; if (tick_o[0] !== et) begin errs++; $display("FAIL b2b_tick i=%0d got=%b exp=%b", i, tick_o[0], et); end
    end
    load = '0;
  endtask

  task automatic test_pause();
    logic et, ec;
    do_reset();
    program_ch(2, 5);
    ec = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      en = (i >= 10 && i <= 16) ? 4'b0000 : 4'b0100;
      step();
      et = (i == 6 || i == 19 || i == 25);
      ec = ec ^ et;
      checks++; if (tick_o[2] !== et) begin errs++; $display("FAIL pause_tick i=%0d got=%b exp=%b", i, tick_o[2], et); end
      checks++; if (clk_o[2] !== ec) begin errs++; $display("FAIL pause_clk i=%0d got=%b exp=%b", i, clk_o[2], ec); end
    end
    step(); step();
    en = 4'b0000; set_div(2, 2); load = 4'b0100;
    step();
    load = '0;
    checks++; if (pend_o[2] !== 1'b1) begin errs++; $display("FAIL pause_ld_pend got=%b exp=1", pend_o[2]); end
    checks++; if (tick_o[2] !== 1'b0) begin errs++; $display("FAIL pause_ld_tick got=%b exp=0", tick_o[2]); end
    step();
    checks++; if (pend_o[2] !== 1'b0) begin errs++; $display("FAIL pause_apply_pend got=%b exp=0", pend_o[2]); end
    en = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      step();
      et = (k == 3); ec = ec ^ et;
      checks++; if (tick_o[2] !== et) begin errs++; $display("FAIL pause_resume_tick k=%0d got=%b exp=%b", k, tick_o[2], et); end
      checks++; if (clk_o[2] !== ec) begin errs++; $display("FAIL pause_resume_clk k=%0d got=%b exp=%b", k, clk_o[2], ec); end
    end
  endtask

  task automatic test_sync();
    logic [NC-1:0] et, ec;
    do_reset();
    set_div(0, 2); set_div(1, 4); set_div(2, 6); load = 4'b0111;
    step();
    load = '0;
    step();
    en = 4'b0001; step();
    en = 4'b0011; step(); step();
    en = 4'b0111; step(); step();
    sync = 1'b1; set_div(3, 1); load = 4'b1000;
    step();
    sync = 1'b0; load = '0;
    checks++; if (tick_o !== 4'b0000) begin errs++; $display("FAIL sync_tick got=%b exp=0000", tick_o); end
    checks++; if (clk_o !== 4'b0000) begin errs++; $display("FAIL sync_clk got=%b exp=0000", clk_o); end
    checks++; if (pend_o !== 4'b1000) begin errs++; $display("FAIL sync_load_pend got=%b exp=1000", pend_o); end
    ec = '0;
    for (int j = 1; j <= 105; j++) begin
      step();
      et = '0;
      for (int c = 0; c < 3; c++) et[c] = (j % (2*c + 3) == 0);
      ec = ec ^ et;
      checks++; if (tick_o !== et) begin errs++; $display("FAIL sync_run_tick j=%0d got=%b exp=%b", j, tick_o, et); end
      checks++; if (clk_o !== ec) begin errs++; $display("FAIL sync_run_clk j=%0d got=%b exp=%b", j, clk_o, ec); end
      checks++; if (pend_o !== 4'b0000) begin errs++; $display("FAIL sync_run_pend j=%0d got=%b exp=0000", j, pend_o); end
    end
  endtask

  task automatic test_reset_mid();
    step(); step();
    set_div(1, 7); load = 4'b0010;
    step();
    load = '0;
    checks++; if (pend_o[1] !== 1'b1) begin errs++; $display("FAIL rstmid_pre_pend got=%b exp=1", pend_o[1]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (tick_o !== 4'b0000) begin errs++; $display("FAIL rstmid_tick got=%b exp=0000", tick_o); end
    checks++; if (clk_o !== 4'b0000) begin errs++; $display("FAIL rstmid_clk got=%b exp=0000", clk_o); end
    checks++; if (pend_o !== 4'b0000) begin errs++; $display("FAIL rstmid_pend got=%b exp=0000", pend_o); end
    step();
    checks++; if (tick_o !== 4'b0111) begin errs++; $display("FAIL rstmid_div0_tick1 got=%b exp=0111", tick_o); end
    checks++; if (clk_o !== 4'b0111) begin errs++; $display("FAIL rstmid_div0_clk1 got=%b exp=0111", clk_o); end
    step();
    checks++; if (tick_o !== 4'b0111) begin errs++; $display("FAIL rstmid_div0_tick2 got=%b exp=0111", tick_o); end
    checks++; if (clk_o !== 4'b0000) begin errs++; $display("FAIL rstmid_div0_clk2 got=%b exp=0000", clk_o); end
  endtask

  initial begin
    rst = 1'b1; en = '0; div = '0; load = '0; sync = 1'b0;
    test_reset();
    test_div3();
    test_div0();
    test_div_max();
    test_load_mid();
    test_load_tc();
    test_back_to_back();
    test_pause();
    test_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multi_prescaler.md
# multi_prescaler

Parametrised multi-channel clock prescaler, the successor of the single-channel toggle divider. Each of `NUM_CH` independent channels divides `clk_i` by a runtime-programmable factor and produces both a one-cycle tick strobe and a divided toggle clock. Divisor updates are double-buffered and take effect only at a period boundary, so outputs never glitch. It sits between the SoC register bank and timing consumers such as PWM, UART baud and sensor sample-rate logic.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1).
- `CNT_W`, 16: counter and divisor width in bits (2..32).
- `RESET_DIV`, 0: divisor loaded into every channel at reset.

- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  NUM_CH  per-channel run enable.
- `div_i`  in  NUM_CH*CNT_W  per-channel divisor; channel c uses bits [c*CNT_W +: CNT_W].
- `load_i`  in  NUM_CH  per-channel one-cycle strobe that captures `div_i` slice into the shadow register.
- `sync_i`  in  1  one-cycle strobe that restarts all channels in phase.
- `tick_o`  out  NUM_CH  one-cycle pulse per completed period.
- `clk_o`  out  NUM_CH  divided toggle output; period 2*(div+1) cycles.
- `pend_o`  out  NUM_CH  shadow divisor waiting to be applied.

## Operation
- Per-channel state: `cnt` (CNT_W), `div_act` (active divisor), `div_sh` (shadow), `pend`, registered `tick_o` and `clk_o`.
- Reset (`rst_i`=1 at an edge): `cnt`=0, `div_act`=`div_sh`=RESET_DIV, `pend`=0, `tick_o`=0, `clk_o`=0 on all channels. Reset overrides every other input.
- Run (`en_i[c]`=1, no sync): if `cnt`==`div_act` (terminal count) then `cnt`<=0, `tick_o`<=1, `clk_o`<=~`clk_o`; else `cnt`<=`cnt`+1, `tick_o`<=0.
- Divide factor = `div_act`+1; `div_act`=0 gives a tick every cycle and `clk_o` toggling every cycle; all-ones gives 2^CNT_W.
- Counter never exceeds `div_act`; no wrap-around path exists, because `div_act` changes only when `cnt`=0 is being loaded.
- Load: `load_i[c]`=1 gives `div_sh`<=slice, `pend`<=1. A repeated load before apply overwrites `div_sh`, and the last value wins.
- Apply, running: at a terminal-count edge with `pend`=1, `div_act`<=`div_sh`, `pend`<=0. The period ending on that edge used the old divisor.
- Apply, disabled: with `en_i[c]`=0 and `pend`=1, on the next edge `div_act`<=`div_sh`, `pend`<=0, `cnt`<=0.
- Simultaneous load and terminal count: the terminal count uses the old `div_act`. The new value goes to shadow and applies at the next terminal count. Any earlier pending value is discarded.
- Disabled (`en_i[c]`=0): `cnt` holds (pause, not clear), `tick_o`=0, `clk_o` holds its level. Re-enable resumes from the held count.
- Sync (`sync_i`=1): all channels `cnt`<=0, `clk_o`<=0, `tick_o`<=0. Pending divisors apply (`div_act`<=`div_sh`, `pend`<=0). A `load_i` in the same cycle still captures to shadow and sets `pend`. Sync acts regardless of `en_i`.
- Channels are fully independent except for the shared `sync_i`.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Enable asserted before edge k with `cnt`=0: `tick_o` is high in the cycle after edge k+`div_act`, then every `div_act`+1 cycles.
- `clk_o` changes in the same cycle that `tick_o` is high.
- `pend_o` rises the cycle after `load_i`. It falls the cycle after the apply edge.
- Sync gives first tick high after edge s+`div_act`+1, counting from the sync edge s.
- Throughput: one channel update per cycle per channel; no stalls.

## Test plan
- Reset then `en_i`=all-ones, div=3 on ch0 -> `tick_o[0]` pulses every 4 cycles, `clk_o[0]` period 8 cycles, 50% duty; `pend_o`=0.
- div=0 on ch1 -> `tick_o[1]` constantly high, `clk_o[1]` toggles every cycle; div=all-ones with CNT_W=4 -> tick every 16 cycles.
- ch0 running at div=9, `load_i` with 2 at `cnt`=4 -> current period completes at 10 cycles, then ticks every 3 cycles; `pend_o` high from load+1 until the apply edge.
- `load_i` coincident with terminal count (div 5 to 1) -> next period is still 6 cycles, then 2-cycle periods.
- Drop `en_i[2]` at `cnt`=3 for 7 cycles -> no ticks, `clk_o[2]` frozen; on resume the tick comes after `div_act`-3 more edges. `load_i` while disabled -> `div_act` updates next edge, `cnt`=0.
- Channels with divs 2/4/6 running out of phase, pulse `sync_i` -> all `clk_o`=0 and counters 0; ticks then align at multiples of LCM. `rst_i` mid-period -> all outputs 0 and `div_act`=RESET_DIV next cycle.
